// File: rtl/burst_addr_gen.sv
// Burst address generator: latches a burst descriptor and issues one address per
// accepted beat (INCR / WRAP / FIXED) with mid-burst abort.
module burst_addr_gen #(
    parameter int ADDR_WIDTH    = 20,
    parameter int COUNTER_WIDTH = 4,
    parameter int STRIDE_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    initial_addr,
    input  logic [COUNTER_WIDTH-1:0] burst_len,
    input  logic [1:0]               mode,
    input  logic [STRIDE_WIDTH-1:0]  stride_log2,
    input  logic                     abort,
    output logic [ADDR_WIDTH-1:0]    burst_addr,
    output logic                     addr_valid,
    input  logic                     addr_ready,
    output logic [COUNTER_WIDTH-1:0] beat_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WRAP  = 2'b01;
    localparam logic [1:0] MODE_FIXED = 2'b10;

    state_t                   r_state;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     r_done;
    logic                     r_aborted;

    // Burst descriptor captured at start; never changes while the burst runs.
    logic [COUNTER_WIDTH-1:0] r_len;
    logic [STRIDE_WIDTH-1:0]  r_stride;
    logic                     r_is_fixed;
    logic                     r_is_wrap;
    logic [ADDR_WIDTH-1:0]    r_wrap_mask;
    logic [ADDR_WIDTH-1:0]    r_base;

    state_t                   w_state_nxt;
    logic [ADDR_WIDTH-1:0]    w_addr_nxt;
    logic [COUNTER_WIDTH-1:0] w_cnt_nxt;
    logic                     w_done_nxt;
    logic                     w_aborted_nxt;
    logic                     w_latch;

    logic [COUNTER_WIDTH:0]   w_beats;
    logic                     w_len_pow2;
    logic [ADDR_WIDTH-1:0]    w_total;
    logic [ADDR_WIDTH-1:0]    w_mask_in;
    logic [ADDR_WIDTH-1:0]    w_stride;
    logic [ADDR_WIDTH-1:0]    w_incr;
    logic [ADDR_WIDTH-1:0]    w_step;

    // WRAP only makes sense for power-of-two beat counts; other lengths fall back to INCR.
    assign w_beats    = {1'b0, burst_len} + 1'b1;
    assign w_len_pow2 = ((w_beats & {1'b0, burst_len}) == '0);
    assign w_total    = ADDR_WIDTH'(w_beats) << stride_log2;
    assign w_mask_in  = w_total - ADDR_WIDTH'(1);

    assign w_stride = ADDR_WIDTH'(1) << r_stride;
    assign w_incr   = r_addr + w_stride;

    always_comb begin
        w_step = w_incr;
        if (r_is_fixed) begin
            w_step = r_addr;
        end else if (r_is_wrap) begin
            w_step = r_base | (w_incr & r_wrap_mask);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_latch       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_BURST;
                    w_addr_nxt  = initial_addr;
                    w_cnt_nxt   = '0;
                end
            end
            S_BURST: begin
                // Abort wins over a beat completing in the same cycle.
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_aborted_nxt = 1'b1;
                end else if (addr_ready) begin
                    if (r_cnt == r_len) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt  = r_cnt + 1'b1;
                        w_addr_nxt = w_step;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_len       <= burst_len;
            r_stride    <= stride_log2;
            r_is_fixed  <= (mode == MODE_FIXED);
            r_is_wrap   <= (mode == MODE_WRAP) && w_len_pow2;
            r_wrap_mask <= w_mask_in;
            r_base      <= initial_addr & ~w_mask_in;
        end
    end

    assign burst_addr = r_addr;
    assign beat_cnt   = r_cnt;
    assign busy       = (r_state == S_BURST);
    assign addr_valid = (r_state == S_BURST);
    assign done       = r_done;
    assign aborted    = r_aborted;

endmodule

// File: tb/tb_burst_addr_gen.sv
// Directed bench for burst_addr_gen: hand-computed address/beat sequences for
// INCR, WRAP, FIXED, backpressure, address-space wrap, abort and mid-burst reset.
module tb_burst_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] initial_addr;
    logic [3:0]  burst_len;
    logic [1:0]  mode;
    logic [1:0]  stride_log2;
    logic        abort;
    logic [19:0] burst_addr;
    logic        addr_valid;
    logic        addr_ready;
    logic [3:0]  beat_cnt;
    logic        busy;
    logic        done;
    logic        aborted;

    int checks = 0;
    int errors = 0;

    burst_addr_gen #(
        .ADDR_WIDTH   (20),
        .COUNTER_WIDTH(4),
        .STRIDE_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .initial_addr(initial_addr),
        .burst_len   (burst_len),
        .mode        (mode),
        .stride_log2 (stride_log2),
        .abort       (abort),
        .burst_addr  (burst_addr),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .beat_cnt    (beat_cnt),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_pulse(input string tag, input logic exp_done, input logic exp_abt);
        chk({tag, "_valid"}, {31'd0, addr_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_aborted"}, {31'd0, aborted}, {31'd0, exp_abt});
    endtask

    task automatic chk_beat(input string tag, input logic [19:0] a, input logic [3:0] c);
        chk({tag, "_addr"}, {12'd0, burst_addr}, {12'd0, a});
        chk({tag, "_cnt"}, {28'd0, beat_cnt}, {28'd0, c});
        chk({tag, "_valid"}, {31'd0, addr_valid}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Presents a descriptor for one cycle; returns with beat 0 visible.
    task automatic start_burst(input logic [19:0] a, input logic [3:0] len,
                               input logic [1:0] m, input logic [1:0] s);
        initial_addr = a;
        burst_len    = len;
        mode         = m;
        stride_log2  = s;
        start        = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [19:0] exp_a [0:5];
    logic        rdy_v [0:5];
    int          vcnt;

    initial begin
        rst = 1'b1; start = 1'b0; initial_addr = '0; burst_len = '0;
        mode = 2'b00; stride_log2 = '0; abort = 1'b0; addr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_addr", {12'd0, burst_addr}, 32'd0);
        chk("rst_cnt", {28'd0, beat_cnt}, 32'd0);
        chk_idle_pulse("rst", 1'b0, 1'b0);

        // INCR, stride 1; descriptor inputs change mid-burst and must be ignored
        start_burst(20'h00010, 4'd3, 2'b00, 2'd0);
        initial_addr = 20'hABCDE; burst_len = 4'd9; mode = 2'b10; stride_log2 = 2'd3;
        for (int i = 0; i < 4; i++) begin
            chk_beat("incr", 20'h00010 + 20'(i), 4'(i));
            tick();
        end
        chk_idle_pulse("incr_end", 1'b1, 1'b0);
        tick();
        chk_idle_pulse("incr_after", 1'b0, 1'b0);

        // WRAP, stride 4, 16-byte window
        start_burst(20'h0000C, 4'd3, 2'b01, 2'd2);
        chk_beat("wrap0", 20'h0000C, 4'd0); tick();
        chk_beat("wrap1", 20'h00000, 4'd1); tick();
        chk_beat("wrap2", 20'h00004, 4'd2); tick();
        chk_beat("wrap3", 20'h00008, 4'd3); tick();
        chk_idle_pulse("wrap_end", 1'b1, 1'b0);

        // WRAP, stride 1, 4-unit window starting mid-window
        start_burst(20'h00105, 4'd3, 2'b01, 2'd0);
        chk_beat("wrapb0", 20'h00105, 4'd0); tick();
        chk_beat("wrapb1", 20'h00106, 4'd1); tick();
        chk_beat("wrapb2", 20'h00107, 4'd2); tick();
        chk_beat("wrapb3", 20'h00104, 4'd3); tick();
        chk_idle_pulse("wrapb_end", 1'b1, 1'b0);

        // WRAP with 3 beats is not a power of two: behaves as INCR
        start_burst(20'h0000E, 4'd2, 2'b01, 2'd0);
        chk_beat("wrapnp0", 20'h0000E, 4'd0); tick();
        chk_beat("wrapnp1", 20'h0000F, 4'd1); tick();
        chk_beat("wrapnp2", 20'h00010, 4'd2); tick();
        chk_idle_pulse("wrapnp_end", 1'b1, 1'b0);

        // Backpressure: ready low on burst cycles 2 and 3
        exp_a = '{20'h00100, 20'h00101, 20'h00101, 20'h00101, 20'h00102, 20'h00103};
        rdy_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vcnt  = 0;
        start_burst(20'h00100, 4'd3, 2'b00, 2'd0);
        for (int i = 0; i < 6; i++) begin
            addr_ready = rdy_v[i];
            chk("bp_addr", {12'd0, burst_addr}, {12'd0, exp_a[i]});
            if (addr_valid) vcnt++;
            tick();
        end
        addr_ready = 1'b1;
        chk("bp_valid_cycles", vcnt, 32'd6);
        chk_idle_pulse("bp_end", 1'b1, 1'b0);

        // Top of address space
        start_burst(20'hFFFFE, 4'd3, 2'b00, 2'd0);
        chk_beat("top0", 20'hFFFFE, 4'd0); tick();
        chk_beat("top1", 20'hFFFFF, 4'd1); tick();
        chk_beat("top2", 20'h00000, 4'd2); tick();
        chk_beat("top3", 20'h00001, 4'd3); tick();
        chk_idle_pulse("top_end", 1'b1, 1'b0);

        // Reserved mode 11 acts as INCR; stride 8
        start_burst(20'h00020, 4'd1, 2'b11, 2'd3);
        chk_beat("rsv0", 20'h00020, 4'd0); tick();
        chk_beat("rsv1", 20'h00028, 4'd1); tick();
        chk_idle_pulse("rsv_end", 1'b1, 1'b0);

        // FIXED, 16 beats
        start_burst(20'h12345, 4'd15, 2'b10, 2'd2);
        for (int i = 0; i < 16; i++) begin
            chk_beat("fixed", 20'h12345, 4'(i));
            tick();
        end
        chk_idle_pulse("fixed_end", 1'b1, 1'b0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle_pulse("idle_abort", 1'b0, 1'b0);

        // Abort with ready on beat 2; a start during the burst is dropped
        start_burst(20'h00200, 4'd7, 2'b00, 2'd0);
        chk_beat("abt0", 20'h00200, 4'd0); tick();
        chk_beat("abt1", 20'h00201, 4'd1);
        start = 1'b1; initial_addr = 20'h00999;
        tick();
        start = 1'b0;
        chk_beat("abt2", 20'h00202, 4'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle_pulse("abt_taken", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_pulse("abt_after", 1'b0, 1'b0);
        end

        // Reset at beat 5 of a 16-beat burst, then a fresh burst
        start_burst(20'h00400, 4'd15, 2'b00, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        chk_beat("mid5", 20'h00405, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_addr", {12'd0, burst_addr}, 32'd0);
        chk("midrst_cnt", {28'd0, beat_cnt}, 32'd0);
        chk_idle_pulse("midrst", 1'b0, 1'b0);
        tick();
        chk_idle_pulse("midrst_after", 1'b0, 1'b0);
        start_burst(20'h00500, 4'd1, 2'b00, 2'd0);
        chk_beat("post0", 20'h00500, 4'd0); tick();
        chk_beat("post1", 20'h00501, 4'd1); tick();
        chk_idle_pulse("post_end", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
